// File: rtl/skinny_round_ctrl.sv
// Round sequencer for a SKINNY-style round-based cipher core.
// It drives load/enable and the 6-bit round constants, UNROLL rounds per clock.
module skinny_round_ctrl #(
  parameter int NR     = 40,
  parameter int UNROLL = 1,
  parameter int CNT_W  = 7
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic                  i_last,
  input  logic                  i_abort,
  input  logic                  i_out_ready,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_core_load,
  output logic                  o_core_en,
  output logic [CNT_W-1:0]      o_round_cnt,
  output logic [6*UNROLL-1:0]   o_rc,
  output logic                  o_done,
  output logic                  o_done_last
);

  // state | meaning
  // IDLE  | no block in flight, start accepted
  // RUN   | rounds executing, datapath updates every cycle
  // DONE  | result held in datapath until out_ready or abort

  generate
    if ((NR % UNROLL) != 0) begin : g_bad_unroll
      $error("skinny_round_ctrl: NR must be a multiple of UNROLL");
    end
    if ((2 ** CNT_W) <= NR) begin : g_bad_cnt_w
      $error("skinny_round_ctrl: CNT_W too narrow for NR");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(NR - UNROLL);
  localparam logic [CNT_W-1:0] LP_STEP     = CNT_W'(UNROLL);
  localparam int               LP_LANE_TOP = 6 * (UNROLL - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [5:0]          r_lfsr;
  logic [5:0]          w_lfsr_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic [6*UNROLL-1:0] w_lanes;
  logic                w_accept;

  function automatic logic [5:0] f_step(input logic [5:0] v);
    return {v[4:0], v[5] ^ v[4] ^ 1'b1};
  endfunction

  // Lane k holds the constant k+1 LFSR steps ahead of the register.
  always_comb begin
    logic [5:0] v;
    v       = r_lfsr;
    w_lanes = '0;
    for (int k = 0; k < UNROLL; k++) begin
      v                = f_step(v);
      w_lanes[6*k +: 6] = v;
    end
  end

  assign w_accept = i_start && !i_abort &&
                    ((r_state == S_IDLE) || ((r_state == S_DONE) && i_out_ready));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_lfsr  <= 6'h00;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    w_last_nxt  = r_last;
    o_ready     = 1'b0;
    o_busy      = 1'b0;
    o_core_load = 1'b0;
    o_core_en   = 1'b0;
    o_round_cnt = '0;
    o_rc        = '0;
    o_done      = 1'b0;
    o_done_last = 1'b0;

    case (r_state)
      S_IDLE: begin
        o_ready = 1'b1;
      end
      S_RUN: begin
        o_busy      = 1'b1;
        o_core_en   = 1'b1;
        o_round_cnt = r_cnt;
        o_rc        = w_lanes;
        w_cnt_nxt   = r_cnt + LP_STEP;
        w_lfsr_nxt  = w_lanes[LP_LANE_TOP +: 6];
        if (r_cnt == LP_CNT_LAST) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
          w_lfsr_nxt  = 6'h00;
        end
      end
      S_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        o_done_last = r_last;
        o_ready     = i_out_ready;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Reload is shared between IDLE and the back-to-back path out of DONE.
    if (w_accept) begin
      o_core_load = 1'b1;
      o_core_en   = 1'b1;
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
      w_lfsr_nxt  = 6'h00;
      w_last_nxt  = i_last;
    end

    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_lfsr_nxt  = 6'h00;
    end
  end

endmodule

// File: tb/tb_skinny_round_ctrl.sv
// Directed bench for skinny_round_ctrl: one UNROLL=1 and one UNROLL=4 instance
// share the same stimulus; expected values are hand-computed constants.
module tb_skinny_round_ctrl;

  logic clk       = 1'b0;
  logic reset     = 1'b1;
  logic start     = 1'b0;
  logic last      = 1'b0;
  logic abort     = 1'b0;
  logic out_ready = 1'b0;

  logic        u1_ready, u1_busy, u1_core_load, u1_core_en, u1_done, u1_done_last;
  logic [6:0]  u1_round_cnt;
  logic [5:0]  u1_rc;
  logic        u4_ready, u4_busy, u4_core_load, u4_core_en, u4_done, u4_done_last;
  logic [6:0]  u4_round_cnt;
  logic [23:0] u4_rc;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_rc [7] = '{6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D};

  always #5 clk = ~clk;

  skinny_round_ctrl #(.NR(40), .UNROLL(1), .CNT_W(7)) u1 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_last(last),
    .i_abort(abort), .i_out_ready(out_ready),
    .o_ready(u1_ready), .o_busy(u1_busy), .o_core_load(u1_core_load),
    .o_core_en(u1_core_en), .o_round_cnt(u1_round_cnt), .o_rc(u1_rc),
    .o_done(u1_done), .o_done_last(u1_done_last)
  );

  skinny_round_ctrl #(.NR(40), .UNROLL(4), .CNT_W(7)) u4 (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_last(last),
    .i_abort(abort), .i_out_ready(out_ready),
    .o_ready(u4_ready), .o_busy(u4_busy), .o_core_load(u4_core_load),
    .o_core_en(u4_core_en), .o_round_cnt(u4_round_cnt), .o_rc(u4_rc),
    .o_done(u4_done), .o_done_last(u4_done_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2 reset = 1'b0;
    #1;
    chk("rst_u1_ready", 32'(u1_ready), 32'd1);
    chk("rst_u1_busy", 32'(u1_busy), 32'd0);
    chk("rst_u1_load", 32'(u1_core_load), 32'd0);
    chk("rst_u1_en", 32'(u1_core_en), 32'd0);
    chk("rst_u1_done", 32'(u1_done), 32'd0);
    chk("rst_u1_dlast", 32'(u1_done_last), 32'd0);
    chk("rst_u1_cnt", 32'(u1_round_cnt), 32'd0);
    chk("rst_u1_rc", 32'(u1_rc), 32'd0);
    chk("rst_u4_ready", 32'(u4_ready), 32'd1);
    chk("rst_u4_busy", 32'(u4_busy), 32'd0);
    chk("rst_u4_load", 32'(u4_core_load), 32'd0);
    chk("rst_u4_en", 32'(u4_core_en), 32'd0);
    chk("rst_u4_done", 32'(u4_done), 32'd0);
    chk("rst_u4_dlast", 32'(u4_done_last), 32'd0);
    chk("rst_u4_cnt", 32'(u4_round_cnt), 32'd0);
    chk("rst_u4_rc", 32'(u4_rc), 32'd0);
    #9 reset = 1'b1;

    // single block, last=1, both unroll factors
    cyc();
    start = 1'b1; last = 1'b1; out_ready = 1'b1;
    #1;
    chk("t1_load_c0", 32'(u1_core_load), 32'd1);
    chk("t1_en_c0", 32'(u1_core_en), 32'd1);
    chk("t1_ready_c0", 32'(u1_ready), 32'd1);
    chk("t1_u4_load_c0", 32'(u4_core_load), 32'd1);
    for (int c = 1; c <= 41; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (c <= 40) begin
        chk("t1_en", 32'(u1_core_en), 32'd1);
        chk("t1_load", 32'(u1_core_load), 32'd0);
        chk("t1_cnt", 32'(u1_round_cnt), 32'(c - 1));
        chk("t1_done", 32'(u1_done), 32'd0);
        chk("t1_ready", 32'(u1_ready), 32'd0);
      end
      if (c <= 7) chk("t1_rc", 32'(u1_rc), 32'(exp_rc[c-1]));
      if (c == 1) begin
        chk("t2_rc_c1", 32'(u4_rc), 32'({6'h0F, 6'h07, 6'h03, 6'h01}));
        chk("t2_cnt_c1", 32'(u4_round_cnt), 32'd0);
      end
      if (c == 2) begin
        chk("t2_cnt_c2", 32'(u4_round_cnt), 32'd4);
        chk("t2_lane0_c2", 32'(u4_rc[5:0]), 32'h1F);
      end
      if (c == 10) begin
        chk("t2_done_c10", 32'(u4_done), 32'd0);
        chk("t2_cnt_c10", 32'(u4_round_cnt), 32'd36);
      end
      if (c == 11) chk("t2_done_c11", 32'(u4_done), 32'd1);
      if (c == 41) begin
        chk("t1_done_c41", 32'(u1_done), 32'd1);
        chk("t1_dlast_c41", 32'(u1_done_last), 32'd1);
        chk("t1_en_c41", 32'(u1_core_en), 32'd0);
        chk("t1_cnt_c41", 32'(u1_round_cnt), 32'd0);
        chk("t1_rc_c41", 32'(u1_rc), 32'd0);
        chk("t1_ready_c41", 32'(u1_ready), 32'd1);
      end
    end
    cyc();
    #1;
    chk("t1_done_c42", 32'(u1_done), 32'd0);
    chk("t1_busy_c42", 32'(u1_busy), 32'd0);

    // backpressure: out_ready low until cycle 46
    cyc();
    start = 1'b1; last = 1'b0; out_ready = 1'b0;
    #1;
    for (int c = 1; c <= 47; c++) begin
      cyc();
      start = 1'b0;
      if (c == 46) out_ready = 1'b1;
      #1;
      if (c == 40) chk("bp_done_c40", 32'(u1_done), 32'd0);
      if (c >= 41 && c <= 45) begin
        chk("bp_done_hold", 32'(u1_done), 32'd1);
        chk("bp_en_hold", 32'(u1_core_en), 32'd0);
        chk("bp_cnt_hold", 32'(u1_round_cnt), 32'd0);
        chk("bp_ready_hold", 32'(u1_ready), 32'd0);
        chk("bp_dlast_hold", 32'(u1_done_last), 32'd0);
      end
      if (c == 46) begin
        chk("bp_done_rel", 32'(u1_done), 32'd1);
        chk("bp_ready_rel", 32'(u1_ready), 32'd1);
      end
      if (c == 47) begin
        chk("bp_done_after", 32'(u1_done), 32'd0);
        chk("bp_busy_after", 32'(u1_busy), 32'd0);
        chk("bp_ready_after", 32'(u1_ready), 32'd1);
      end
    end

    // back-to-back: blocks accepted at 0, 41, 82 with last = 0, 1, 0
    cyc();
    start = 1'b1; last = 1'b0; out_ready = 1'b1;
    #1;
    chk("b2b_load_c0", 32'(u1_core_load), 32'd1);
    for (int c = 1; c <= 124; c++) begin
      logic exp_done;
      cyc();
      if (c == 41) last = 1'b1;
      if (c == 82) last = 1'b0;
      if (c == 123) start = 1'b0;
      #1;
      exp_done = (c == 41) || (c == 82) || (c == 123);
      if (c <= 123) chk("b2b_done", 32'(u1_done), 32'(exp_done));
      if (c == 41) begin
        chk("b2b_load_c41", 32'(u1_core_load), 32'd1);
        chk("b2b_dlast_c41", 32'(u1_done_last), 32'd0);
      end
      if (c == 82) begin
        chk("b2b_load_c82", 32'(u1_core_load), 32'd1);
        chk("b2b_dlast_c82", 32'(u1_done_last), 32'd1);
      end
      if (c == 123) begin
        chk("b2b_dlast_c123", 32'(u1_done_last), 32'd0);
        chk("b2b_load_c123", 32'(u1_core_load), 32'd0);
      end
      if (c == 42) chk("b2b_cnt_c42", 32'(u1_round_cnt), 32'd0);
      if (c == 43) chk("b2b_cnt_c43", 32'(u1_round_cnt), 32'd1);
      if (c == 124) chk("b2b_busy_end", 32'(u1_busy), 32'd0);
    end

    // abort at round 20 with start also high
    cyc();
    start = 1'b1; last = 1'b1;
    #1;
    for (int c = 1; c <= 21; c++) begin
      cyc();
      start = (c == 21);
      abort = (c == 21);
      #1;
      if (c == 21) chk("ab_cnt_c21", 32'(u1_round_cnt), 32'd20);
    end
    cyc();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("ab_ready", 32'(u1_ready), 32'd1);
    chk("ab_busy", 32'(u1_busy), 32'd0);
    chk("ab_done", 32'(u1_done), 32'd0);
    chk("ab_cnt", 32'(u1_round_cnt), 32'd0);
    for (int c = 0; c < 45; c++) begin
      cyc();
      #1;
      chk("ab_no_done", 32'(u1_done), 32'd0);
    end
    cyc();
    start = 1'b1; last = 1'b0;
    #1;
    chk("ab_fresh_load", 32'(u1_core_load), 32'd1);
    for (int c = 1; c <= 41; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (c == 1) chk("ab_fresh_rc", 32'(u1_rc), 32'h01);
      if (c == 40) chk("ab_fresh_done40", 32'(u1_done), 32'd0);
      if (c == 41) begin
        chk("ab_fresh_done41", 32'(u1_done), 32'd1);
        chk("ab_fresh_dlast", 32'(u1_done_last), 32'd0);
      end
    end
    cyc();
    #1;

    // asynchronous reset in the middle of RUN
    cyc();
    start = 1'b1;
    #1;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      start = 1'b0;
      #1;
      if (c == 16) chk("rr_cnt_c16", 32'(u1_round_cnt), 32'd15);
    end
    reset = 1'b0;
    #1;
    chk("rr_ready", 32'(u1_ready), 32'd1);
    chk("rr_busy", 32'(u1_busy), 32'd0);
    chk("rr_en", 32'(u1_core_en), 32'd0);
    chk("rr_cnt", 32'(u1_round_cnt), 32'd0);
    chk("rr_rc", 32'(u1_rc), 32'd0);
    chk("rr_done", 32'(u1_done), 32'd0);
    cyc();
    reset = 1'b1;
    cyc();
    start = 1'b1;
    #1;
    chk("rr_load", 32'(u1_core_load), 32'd1);
    cyc();
    start = 1'b0;
    #1;
    chk("rr_rc_again", 32'(u1_rc), 32'h01);
    chk("rr_cnt_again", 32'(u1_round_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
